// File: rtl/hex_echo.sv
// Purpose: accumulates ASCII hex digits from a byte stream and, on CR or LF, echoes "=<hex>\r\n" (or "?\r\n").
// Latency: the first response byte is valid on the cycle after the terminator is accepted, then one byte per accepted cycle.
// Backpressure: the response holds while in_ready_i=0; input is refused (out_ready_o=0) for the whole response.
//
// Ports:
//   clk_1mhz, rstn          clock, asynchronous active-low reset
//   out_data_i/_valid_i     host-to-device byte stream (out_ready_o = accept)
//   in_data_o/_valid_o      device-to-host response stream (in_ready_i = accept)
//   value_o                 last committed value, zero-extended to 32 bits
//   busy_o                  response in progress
module hex_echo #(
  parameter int DIGITS = 8
) (
  input  logic        clk_1mhz,
  input  logic        rstn,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic [31:0] value_o,
  output logic        busy_o
);

  localparam int         AW       = 4 * DIGITS;
  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);
  localparam logic [3:0] MAX_CNT  = 4'(DIGITS);

  typedef enum logic [2:0] {RX, TX_HDR, TX_DIG, TX_CR, TX_LF} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc;
  logic [AW-1:0] value_r;
  logic [3:0]    cnt;
  logic          err;
  logic [2:0]    idx;
  logic          run;      // holds out_ready_o low until the first edge after reset release

  logic          rx_xfer, tx_xfer;
  logic          is_hex, is_term;
  logic [3:0]    nib;
  logic [31:0]   value32;
  logic [2:0]    sh;
  logic [3:0]    dig;

  assign rx_xfer = out_valid_i && out_ready_o;
  assign tx_xfer = in_valid_o && in_ready_i;
  assign is_term = (out_data_i == 8'h0D) || (out_data_i == 8'h0A);
  assign value32 = 32'(value_r);
  assign value_o = value32;

  // ASCII hex decode of the incoming byte
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (out_data_i >= 8'h30 && out_data_i <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(out_data_i - 8'h30);
    end else if (out_data_i >= 8'h41 && out_data_i <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(out_data_i - 8'h37);
    end else if (out_data_i >= 8'h61 && out_data_i <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(out_data_i - 8'h57);
    end
  end

  // Digit idx 0 is the most significant nibble of the committed value
  assign sh  = LAST_IDX - idx;
  assign dig = 4'(value32 >> {sh, 2'b00});

  // State register
  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn) state <= RX;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RX:     if (rx_xfer && is_term && (err || cnt != 4'd0)) state_nxt = TX_HDR;
      TX_HDR: if (tx_xfer) state_nxt = err ? TX_CR : TX_DIG;
      TX_DIG: if (tx_xfer && idx == LAST_IDX) state_nxt = TX_CR;
      TX_CR:  if (tx_xfer) state_nxt = TX_LF;
      TX_LF:  if (tx_xfer) state_nxt = RX;
      default: state_nxt = RX;
    endcase
  end

  // Outputs; all decoded from state so reset clears them asynchronously
  always_comb begin
    out_ready_o = run && (state == RX);
    in_valid_o  = (state != RX);
    busy_o      = (state != RX);
    in_data_o   = 8'h00;
    case (state)
      TX_HDR: in_data_o = err ? 8'h3F : 8'h3D;
      TX_DIG: in_data_o = (dig < 4'd10) ? (8'h30 + {4'h0, dig}) : (8'h37 + {4'h0, dig});
      TX_CR:  in_data_o = 8'h0D;
      TX_LF:  in_data_o = 8'h0A;
      default: in_data_o = 8'h00;
    endcase
  end

  // Datapath: accumulator, digit count, error flag, committed value, digit index
  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn) begin
      acc     <= '0;
      value_r <= '0;
      cnt     <= 4'd0;
      err     <= 1'b0;
      idx     <= 3'd0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        RX: begin
          if (rx_xfer) begin
            if (is_term) begin
              if (!err && cnt != 4'd0) value_r <= acc;
            end else if (is_hex) begin
              // After an error, digits are swallowed until the terminator
              if (!err) begin
                acc <= AW'({acc, nib});
                if (cnt != MAX_CNT) cnt <= cnt + 4'd1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        TX_HDR: idx <= 3'd0;
        TX_DIG: if (tx_xfer) idx <= idx + 3'd1;
        TX_LF: begin
          if (tx_xfer) begin
            acc <= '0;
            cnt <= 4'd0;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hex_echo.md
HEX_ECHO -- requirements
Module: hex_echo

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of hex digits accumulated and echoed (legal 1..8).
REQ-002 SHALL have port clk_1mhz  input  1  block clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port out_data_i  input  8  host-to-device byte from the USB CDC application side.
REQ-005 SHALL have port out_valid_i  input  1  out_data_i valid.
REQ-006 SHALL have port out_ready_o  output  1  block accepts out_data_i.
REQ-007 SHALL have port in_data_o  output  8  device-to-host response byte.
REQ-008 SHALL have port in_valid_o  output  1  in_data_o valid.
REQ-009 SHALL have port in_ready_i  input  1  sink accepts in_data_o.
REQ-010 SHALL have port value_o  output  32  last committed value, zero-extended from 4*DIGITS bits.
REQ-011 SHALL have port busy_o  output  1  response in progress.

Function
REQ-012 A byte SHALL transfer on a rising edge where valid and ready are both 1; there SHALL be no other transfer condition.
REQ-013 The FSM states SHALL be RX, TX_HDR, TX_DIG, TX_CR and TX_LF.
REQ-014 out_ready_o SHALL be 1 only in RX; in_valid_o and busy_o SHALL be 1 only in the TX_* states.
REQ-015 In RX, an accepted byte '0'-'9', 'A'-'F' or 'a'-'f' SHALL update acc <= {acc[4*DIGITS-5:0], nibble} and cnt <= min(cnt+1, DIGITS).
REQ-016 When more than DIGITS digits arrive, older digits SHALL be shifted out, with no error.
REQ-017 In RX, an accepted byte 0x0D or 0x0A with cnt=0 and err=0 SHALL be ignored, so CRLF and empty lines produce no response.
REQ-018 In RX, an accepted terminator with err=0 and cnt>0 SHALL set value_o <= acc and move to TX_HDR.
REQ-019 In RX, an accepted terminator with err=1 SHALL leave value_o unchanged and move to TX_HDR in error mode.
REQ-020 In RX, any other accepted byte SHALL set err=1; later digits SHALL still be consumed but ignored.
REQ-021 Normal response SHALL be '=' (0x3D), then DIGITS uppercase ASCII hex digits of the committed value, MS nibble first, then 0x0D, then 0x0A.
REQ-022 Error response SHALL be '?' (0x3F), then 0x0D, then 0x0A, skipping TX_DIG.
REQ-023 in_valid_o SHALL be 1 on the cycle after the terminator is accepted.
REQ-024 With in_ready_i held at 1, response bytes SHALL transfer one per cycle.
REQ-025 While in_valid_o=1 and in_ready_i=0, in_data_o SHALL be held stable and in_valid_o SHALL stay 1.
REQ-026 TX_DIG SHALL use a digit index of 3 bits; it SHALL advance only on a transfer and leave TX_DIG after index DIGITS-1.
REQ-027 On transfer of 0x0A, the block SHALL clear acc, cnt and err and return to RX; out_ready_o SHALL be 1 on the following cycle.
REQ-028 out_valid_i SHALL be ignored in every TX_* state, with no byte consumed.
REQ-029 in_ready_i SHALL be ignored in RX.

Reset
REQ-030 While rstn=0, the block SHALL hold out_ready_o=0, in_valid_o=0, in_data_o=0x00, busy_o=0, value_o=0, acc=0, cnt=0, err=0 and state RX.
REQ-031 out_ready_o SHALL go to 1 on the first rising edge after rstn deasserts.
REQ-032 rstn assertion mid-response SHALL drop in_valid_o immediately (asynchronously) with no further bytes; the block SHALL restart in RX after release.

Verification
REQ-033 SHALL test: "1A2b" then 0x0D, ready=1 -> bytes "=00001A2B" 0x0D 0x0A on 11 consecutive cycles; value_o=0x00001A2B; busy_o high exactly 11 cycles.
REQ-034 SHALL test: "7F" 0x0D 0x0A -> a single response "=0000007F\r\n"; the trailing 0x0A produces nothing.
REQ-035 SHALL test: "12G4" 0x0D -> "?\r\n"; value_o keeps its prior value.
REQ-036 SHALL test: "123456789" 0x0D -> "=23456789\r\n"; value_o=0x23456789.
REQ-037 SHALL test: in_ready_i held 0 for 3 cycles while the 3rd digit is presented -> in_data_o and in_valid_o stable throughout; out_ready_o=0; no byte lost or duplicated.
REQ-038 SHALL test: rstn pulsed low during TX_DIG -> in_valid_o=0 and value_o=0 at once; after release, "5" 0x0D -> "=00000005\r\n".
